// File: rtl/seg_scan_driver_if.sv
// Signal bundle between the segment-decode stage and the scan driver:
// per-digit patterns and controls in, multiplexed pin drive out.
interface seg_scan_driver_if;
    logic [3:0][6:0] disp;
    logic [2:0]      bright;
    logic            enable;
    logic [6:0]      seg;
    logic [3:0]      an;
    logic            frame_tick;

    modport master (
        output disp, bright, enable,
        input  seg, an, frame_tick
    );

    modport slave (
        input  disp, bright, enable,
        output seg, an, frame_tick
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode scan driver: one shared active-low segment bus,
// per-slot blanking gap and 8-level PWM brightness, all outputs registered.
module seg_scan_driver #(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter logic [6:0]  SEG_OFF      = 7'h7F
) (
    input  logic             clk,
    input  logic             reset,
    seg_scan_driver_if.slave bus
);

    localparam int unsigned    CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  CNT_ON   = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [2:0]    p;
    logic [6:0]    pat;

    logic          slot_end;
    logic          on_phase;
    logic          lit;
    logic [6:0]    seg_d;
    logic [3:0]    an_d;
    logic          tick_d;

    always_comb begin
        slot_end = (cnt == CNT_LAST);
        on_phase = (cnt >= CNT_ON);
        lit      = bus.enable && on_phase && (p <= bus.bright);
        seg_d    = SEG_OFF;
        an_d     = '1;
        tick_d   = bus.enable && slot_end && (idx == 2'd3);
        if (lit) begin
            seg_d = pat;
            an_d  = ~(4'b0001 << idx);
        end
    end

    // p is held at 0 through the blank phase so it reads 0 on the first on-phase cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
            p   <= '0;
            pat <= SEG_OFF;
        end else if (!bus.enable) begin
            cnt <= '0;
            idx <= '0;
            p   <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= idx + 1'b1;
            end
            p <= on_phase ? p + 1'b1 : '0;
            if (cnt == '0) begin
                pat <= bus.disp[idx];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.seg        <= SEG_OFF;
            bus.an         <= '1;
            bus.frame_tick <= 1'b0;
        end else begin
            bus.seg        <= seg_d;
            bus.an         <= an_d;
            bus.frame_tick <= tick_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a cycle-count model predicts each
// registered output before the clock edge, the prediction is checked after it.
module tb_seg_scan_driver;

    localparam int unsigned CLK_DIV = 16;
    localparam int unsigned BLANK   = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seg_scan_driver_if bus ();

    seg_scan_driver #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK),
        .SEG_OFF      (7'h7F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       tick;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned mt       = 0;
    logic [6:0]  mlatch   = 7'h7F;
    int          cyc      = 0;
    int          last_tick = -1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Predicts the output visible after the coming edge from enabled-cycle count mt
    task automatic model_push();
        int unsigned pos = mt % CLK_DIV;
        int unsigned dig = (mt / CLK_DIV) % 4;
        exp_t e;
        e.seg  = 7'h7F;
        e.an   = 4'hF;
        e.tick = 1'b0;
        if (bus.enable) begin
            if (pos >= BLANK && ((pos - BLANK) % 8) <= 32'(bus.bright)) begin
                e.seg = mlatch;
                e.an  = an_tab[dig];
            end
            e.tick = (pos == CLK_DIV - 1) && (dig == 3);
            if (pos == 0) mlatch = bus.disp[dig];
            mt++;
        end else begin
            mt = 0;
        end
        sb.push_back(e);
    endtask

    task automatic model_reset();
        mt        = 0;
        mlatch    = 7'h7F;
        last_tick = -1;
        sb.delete();
    endtask

    // Called at a negedge with inputs settled; returns at the next negedge.
    task automatic cycle();
        exp_t e;
        model_push();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("seg", 32'(bus.seg), 32'(e.seg));
        check("an", 32'(bus.an), 32'(e.an));
        check("frame_tick", 32'(bus.frame_tick), 32'(e.tick));
        check("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
        cyc++;
        if (bus.frame_tick) begin
            if (last_tick >= 0) check("tick_period", 32'(cyc - last_tick), 32'd64);
            last_tick = cyc;
        end
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_seg"}, 32'(bus.seg), 32'h7F);
        check({tag, "_an"}, 32'(bus.an), 32'hF);
        check({tag, "_tick"}, 32'(bus.frame_tick), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int cnt_e;
        int ticks;
        int lit_n;
        int first;
        bit found;

        bus.enable  = 1'b0;
        bus.bright  = 3'd7;
        bus.disp[0] = 7'h40;
        bus.disp[1] = 7'h79;
        bus.disp[2] = 7'h24;
        bus.disp[3] = 7'h7F;

        // Asynchronous reset between edges
        #12;
        reset = 1'b1;
        bus.enable = 1'b1;
        #1;
        check_reset_vals("rst_async");
        @(posedge clk);
        #1;
        check_reset_vals("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Full brightness scan, two frames
        cnt_e = 0;
        ticks = 0;
        for (int i = 0; i < 128; i++) begin
            cycle();
            if (i < 64 && bus.an == 4'hE) cnt_e++;
            if (bus.frame_tick) ticks++;
        end
        check("d0_lit_cycles", 32'(cnt_e), 32'd12);
        check("ticks_two_frames", 32'(ticks), 32'd2);

        // Mid-slot update of digit 1 at cnt = 8 of slot 1
        for (int i = 0; i < 24; i++) cycle();
        bus.disp[1] = 7'h12;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (bus.an == 4'hD) check("midslot_hold", 32'(bus.seg), 32'h79);
        end
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (bus.an == 4'hD) check("next_slot_new", 32'(bus.seg), 32'h12);
        end

        // Minimum brightness: 2 lit cycles per slot
        bus.bright = 3'd0;
        lit_n = 0;
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (bus.an != 4'hF) lit_n++;
        end
        check("min_bright_lit", 32'(lit_n), 32'd8);
        bus.bright = 3'd7;

        // Enable toggle inside slot 2
        for (int i = 0; i < 6; i++) cycle();
        check("slot2_lit", 32'(bus.an), 32'hB);
        bus.enable = 1'b0;
        last_tick = -1;
        cycle();
        check_reset_vals("en_low");
        for (int i = 0; i < 3; i++) cycle();
        bus.enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("en_restart_blank", 32'(bus.an), 32'hF);
        end
        cycle();
        check("en_restart_d0", 32'(bus.an), 32'hE);

        // Async reset while digit 3 is lit
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            cycle();
            if (bus.an == 4'h7) found = 1'b1;
        end
        check("find_d3_lit", 32'(found), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("rst_midscan");
        @(posedge clk);
        #1;
        check_reset_vals("rst_midscan_hold");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        first = 0;
        for (int i = 1; i <= 70; i++) begin
            cycle();
            if (i <= 16 && bus.an != 4'hF) check("resume_d0", 32'(bus.an), 32'hE);
            if (bus.frame_tick && first == 0) first = i;
        end
        check("first_tick_after_reset", 32'(first), 32'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
